// File: rtl/ucsbece154b_mem_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and grant owner.
package ucsbece154b_mem_pkg;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_ISSUE = 2'd1,
    MA_WAIT  = 2'd2,
    MA_RESP  = 2'd3
  } ma_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/ucsbece154b_arb_pick.sv
// Combinational winner select: data beats fetch unless the starvation guard fires.
module ucsbece154b_arb_pick
  import ucsbece154b_mem_pkg::*;
(
  input  logic ireq,
  input  logic dreq,
  input  logic starve_fire,
  output logic vld,
  output gnt_t gnt
);

  always_comb begin
    vld = ireq | dreq;
    gnt = GNT_I;
    if (dreq && !(starve_fire && ireq)) gnt = GNT_D;
  end

endmodule

// File: rtl/ucsbece154b_mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store, one transaction at a time.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_MAX data grants.
module ucsbece154b_mem_arbiter
  import ucsbece154b_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IReq_i,
  input  logic [ADDR_W-1:0] IAddr_i,
  output logic [DATA_W-1:0] IRdata_o,
  output logic              IDone_o,
  input  logic              DReq_i,
  input  logic              DWe_i,
  input  logic [ADDR_W-1:0] DAddr_i,
  input  logic [DATA_W-1:0] DWdata_i,
  output logic [DATA_W-1:0] DRdata_o,
  output logic              DDone_o,
  output logic              MemEn_o,
  output logic              MemWe_o,
  output logic [ADDR_W-1:0] MemAddr_o,
  output logic [DATA_W-1:0] MemWdata_o,
  input  logic [DATA_W-1:0] MemRdata_i,
  input  logic              MemReady_i,
  output logic              Busy_o
);

  ma_state_t         state, state_nxt;
  gnt_t              gnt_q, pick_gnt;
  logic              pick_vld;
  logic              starve_fire;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;
  logic              grant_now;

  ucsbece154b_arb_pick u_pick (
    .ireq        (IReq_i),
    .dreq        (DReq_i),
    .starve_fire (starve_fire),
    .vld         (pick_vld),
    .gnt         (pick_gnt)
  );

  assign grant_now = (state == MA_IDLE) && pick_vld;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  assign starve_fire = IReq_i && (starve_cnt == STARVE_LIM);

  // Counts only data grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == MA_IDLE) begin
      if (!IReq_i || pick_gnt == GNT_I) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign starve_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= MA_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    MemEn_o   = 1'b0;
    Busy_o    = 1'b1;
    IDone_o   = 1'b0;
    DDone_o   = 1'b0;
    case (state)
      MA_IDLE: begin
        Busy_o = 1'b0;
        if (pick_vld) state_nxt = MA_ISSUE;
      end
      MA_ISSUE: begin
        MemEn_o   = 1'b1;
        state_nxt = MA_WAIT;
      end
      MA_WAIT: begin
        if (MemReady_i) state_nxt = MA_RESP;
      end
      MA_RESP: begin
        IDone_o   = (gnt_q == GNT_I);
        DDone_o   = (gnt_q == GNT_D);
        state_nxt = MA_IDLE;
      end
      default: state_nxt = MA_IDLE;
    endcase
  end

  // Requester attributes are captured once at grant; later input changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= GNT_I;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      if (grant_now) begin
        gnt_q <= pick_gnt;
        if (pick_gnt == GNT_D) begin
          addr_q  <= DAddr_i;
          we_q    <= DWe_i;
          wdata_q <= DWdata_i;
        end else begin
          addr_q  <= IAddr_i;
          we_q    <= 1'b0;
          wdata_q <= '0;
        end
      end
      if (state == MA_WAIT && MemReady_i) begin
        if (gnt_q == GNT_I)  irdata_q <= MemRdata_i;
        else if (!we_q)      drdata_q <= MemRdata_i;
      end
    end
  end

  assign MemWe_o    = we_q;
  assign MemAddr_o  = addr_q;
  assign MemWdata_o = wdata_q;
  assign IRdata_o   = irdata_q;
  assign DRdata_o   = drdata_q;

  a_starve_max_min: assert property (@(posedge clk) STARVE_MAX >= 1);
  a_en_one_cycle:   assert property (@(posedge clk) disable iff (reset) MemEn_o |=> !MemEn_o);
  a_done_onehot:    assert property (@(posedge clk) !(IDone_o && DDone_o));

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for ucsbece154b_mem_arbiter: vector table plus corner-case sequences.
module tb_ucsbece154b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReq_i;
  logic [31:0] IAddr_i;
  logic [31:0] IRdata_o;
  logic        IDone_o;
  logic        DReq_i;
  logic        DWe_i;
  logic [31:0] DAddr_i;
  logic [31:0] DWdata_i;
  logic [31:0] DRdata_o;
  logic        DDone_o;
  logic        MemEn_o;
  logic        MemWe_o;
  logic [31:0] MemAddr_o;
  logic [31:0] MemWdata_o;
  logic [31:0] MemRdata_i;
  logic        MemReady_i;
  logic        Busy_o;

  always #5 clk = ~clk;

  ucsbece154b_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .IReq_i     (IReq_i),
    .IAddr_i    (IAddr_i),
    .IRdata_o   (IRdata_o),
    .IDone_o    (IDone_o),
    .DReq_i     (DReq_i),
    .DWe_i      (DWe_i),
    .DAddr_i    (DAddr_i),
    .DWdata_i   (DWdata_i),
    .DRdata_o   (DRdata_o),
    .DDone_o    (DDone_o),
    .MemEn_o    (MemEn_o),
    .MemWe_o    (MemWe_o),
    .MemAddr_o  (MemAddr_o),
    .MemWdata_o (MemWdata_o),
    .MemRdata_i (MemRdata_i),
    .MemReady_i (MemReady_i),
    .Busy_o     (Busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrdata;
    int          lat;
    logic        exp_d;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ir;
    logic [31:0] exp_dr;
  } vec_t;

  // Serves one memory transaction: waits for the issue strobe, answers after k cycles,
  // and reports what the arbiter presented and returned.
  task automatic serve(input int k, input logic [31:0] rd,
                       output int issue_wait, output logic got_d,
                       output logic [31:0] a, output logic w, output logic [31:0] wd,
                       output int en_extra, output int busy_drop, output int done_lat,
                       output logic [31:0] ir, output logic [31:0] dr);
    logic seen;
    seen = 1'b0; issue_wait = 0; en_extra = 0; busy_drop = 0; done_lat = 0;
    got_d = 1'b0; a = '0; w = 1'b0; wd = '0; ir = '0; dr = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      issue_wait++;
      seen = MemEn_o;
    end
    if (!seen) begin
      chk("issue_timeout", 32'd0, 32'd1);
      return;
    end
    a = MemAddr_o; w = MemWe_o; wd = MemWdata_o;
    for (int j = 1; j <= k; j++) begin
      @(negedge clk);
      if (MemEn_o) en_extra++;
      if (!Busy_o) busy_drop++;
      if (j == k) begin
        MemReady_i = 1'b1;
        MemRdata_i = rd;
      end
    end
    seen = 1'b0;
    for (int m = 1; m <= 3 && !seen; m++) begin
      @(negedge clk);
      MemReady_i = 1'b0;
      MemRdata_i = 32'h5A5A_0000;
      seen = IDone_o | DDone_o;
      done_lat = k + m;
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    got_d = DDone_o; ir = IRdata_o; dr = DRdata_o;
    chk("done_onehot", {31'b0, IDone_o & DDone_o}, 32'd0);
  endtask

  vec_t        vecs[6];
  int          iw, ex, bd, dl, pulses, busy_seen;
  logic        gd, ww;
  logic [31:0] aa, wdd, irr, drr;
  logic [5:0]  starve_exp;

  initial begin
    reset = 1'b1; IReq_i = 1'b0; IAddr_i = '0; DReq_i = 1'b0; DWe_i = 1'b0;
    DAddr_i = '0; DWdata_i = '0; MemRdata_i = '0; MemReady_i = 1'b0;

    //            ireq   iaddr         dreq  dwe   daddr         dwdata        mrdata        lat d    addr          we    wdata         ir            dr
    vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,        32'h0,        32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b1, 32'h0000_0180, 1'b1, 1'b0, 32'h0000_0200, 32'h77,      32'h0000_1234, 2, 1'b1, 32'h0000_0200, 1'b0, 32'h0,        32'hDEAD_BEEF, 32'h0000_1234};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_0040, 1'b1, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 32'h0000_1234};
    vecs[3] = '{1'b1, 32'h0000_0104, 1'b0, 1'b1, 32'h0000_0999, 32'h55,      32'h0000_0013, 5, 1'b0, 32'h0000_0104, 1'b0, 32'h0,        32'h0000_0013, 32'h0000_1234};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0000_0044, 32'h0,        32'hCAFE_F00D, 1, 1'b1, 32'h0000_0044, 1'b0, 32'h0,        32'h0000_0013, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 32'h0000_0108, 1'b1, 1'b1, 32'h0000_0048, 32'h0BAD_F00D, 32'h1111_1111, 3, 1'b1, 32'h0000_0048, 1'b1, 32'h0BAD_F00D, 32'h0000_0013, 32'hCAFE_F00D};

`ifdef MEM_ARB_STARVE_GUARD_EN
    starve_exp = 6'b011011;
`else
    starve_exp = 6'b111111;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {27'b0, MemEn_o, MemWe_o, IDone_o, DDone_o, Busy_o}, 32'd0);
    chk("rst_memaddr", MemAddr_o, 32'd0);
    chk("rst_memwdata", MemWdata_o, 32'd0);
    chk("rst_irdata", IRdata_o, 32'd0);
    chk("rst_drdata", DRdata_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'b0, Busy_o}, 32'd0);

    // Single transactions from the table
    for (int v = 0; v < 6; v++) begin
      IReq_i = vecs[v].ireq; IAddr_i = vecs[v].iaddr; DReq_i = vecs[v].dreq;
      DWe_i = vecs[v].dwe; DAddr_i = vecs[v].daddr; DWdata_i = vecs[v].dwdata;
      serve(vecs[v].lat, vecs[v].mrdata, iw, gd, aa, ww, wdd, ex, bd, dl, irr, drr);
      chk($sformatf("v%0d_issue_lat", v), iw, 32'd1);
      chk($sformatf("v%0d_gnt", v), {31'b0, gd}, {31'b0, vecs[v].exp_d});
      chk($sformatf("v%0d_addr", v), aa, vecs[v].exp_addr);
      chk($sformatf("v%0d_we", v), {31'b0, ww}, {31'b0, vecs[v].exp_we});
      if (vecs[v].exp_we) chk($sformatf("v%0d_wdata", v), wdd, vecs[v].exp_wdata);
      chk($sformatf("v%0d_en_extra", v), ex, 32'd0);
      chk($sformatf("v%0d_done_lat", v), dl, vecs[v].lat + 1);
      chk($sformatf("v%0d_irdata", v), irr, vecs[v].exp_ir);
      chk($sformatf("v%0d_drdata", v), drr, vecs[v].exp_dr);
      IReq_i = 1'b0; DReq_i = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_ir_hold", v), IRdata_o, vecs[v].exp_ir);
      chk($sformatf("v%0d_dr_hold", v), DRdata_o, vecs[v].exp_dr);
    end

    // Simultaneous requests: data first, then fetch in the following IDLE
    IReq_i = 1'b1; IAddr_i = 32'h500; DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h600;
    serve(2, 32'h2222, iw, gd, aa, ww, wdd, ex, bd, dl, irr, drr);
    chk("sim_first_gnt", {31'b0, gd}, 32'd1);
    chk("sim_first_addr", aa, 32'h600);
    chk("sim_first_dr", drr, 32'h2222);
    DReq_i = 1'b0;
    serve(1, 32'h3333, iw, gd, aa, ww, wdd, ex, bd, dl, irr, drr);
    chk("sim_second_wait", iw, 32'd2);
    chk("sim_second_gnt", {31'b0, gd}, 32'd0);
    chk("sim_second_addr", aa, 32'h500);
    chk("sim_second_ir", irr, 32'h3333);
    IReq_i = 1'b0;
    repeat (2) @(negedge clk);

    // Starvation: data continuously re-requests while fetch waits
    IReq_i = 1'b1; IAddr_i = 32'h300; DReq_i = 1'b1; DWe_i = 1'b0; DAddr_i = 32'h400;
    for (int g = 0; g < 6; g++) begin
      serve(1, 32'h100 + g, iw, gd, aa, ww, wdd, ex, bd, dl, irr, drr);
      chk($sformatf("starve_gnt%0d", g), {31'b0, gd}, {31'b0, starve_exp[g]});
      if (gd) DAddr_i = DAddr_i + 32'd4;
      else    IAddr_i = IAddr_i + 32'd4;
    end
    IReq_i = 1'b0; DReq_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while in WAIT aborts the transaction
    DReq_i = 1'b1; DWe_i = 1'b1; DAddr_i = 32'h700; DWdata_i = 32'h7777;
    iw = 0;
    for (int i = 0; i < 8 && !MemEn_o; i++) begin
      @(negedge clk);
      iw++;
    end
    chk("rstw_issued", {31'b0, MemEn_o}, 32'd1);
    @(negedge clk);
    chk("rstw_busy_before", {31'b0, Busy_o}, 32'd1);
    reset = 1'b1; DReq_i = 1'b0;
    @(negedge clk);
    reset = 1'b0; MemReady_i = 1'b1; MemRdata_i = 32'hBAD0_BAD0;
    pulses = 0; busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MemReady_i = 1'b0;
      if (IDone_o || DDone_o) pulses++;
      if (Busy_o) busy_seen++;
    end
    chk("rstw_no_done", pulses, 32'd0);
    chk("rstw_busy", busy_seen, 32'd0);
    chk("rstw_ctrl", {27'b0, MemEn_o, MemWe_o, IDone_o, DDone_o, Busy_o}, 32'd0);
    chk("rstw_memaddr", MemAddr_o, 32'd0);
    chk("rstw_memwdata", MemWdata_o, 32'd0);
    chk("rstw_irdata", IRdata_o, 32'd0);
    chk("rstw_drdata", DRdata_o, 32'd0);

    // Long latency: ready 20 cycles after issue
    IReq_i = 1'b1; IAddr_i = 32'h800;
    serve(20, 32'hFEED_FACE, iw, gd, aa, ww, wdd, ex, bd, dl, irr, drr);
    IReq_i = 1'b0;
    chk("long_busy_drop", bd, 32'd0);
    chk("long_en_in_wait", ex, 32'd0);
    chk("long_done_lat", dl, 32'd21);
    chk("long_ir", irr, 32'hFEED_FACE);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (IDone_o || DDone_o) pulses++;
    end
    chk("long_single_done", pulses, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ucsbece154b_mem_arbiter.md
# ucsbece154b_mem_arbiter

Arbitrates a single shared backing-memory port between the pipeline's instruction-fetch requester and its load/store (data) requester. Sits between the fetch/memory stages and the unified memory, sequencing one transaction at a time through a request/issue/wait/respond state machine. Provides per-requester done pulses so the hazard logic can hold `StallF`/`StallD`/`StallM` until each access completes. Data accesses have priority; an optional starvation guard protects fetch.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `STARVE_MAX`, 4, consecutive data grants tolerated while fetch waits (guard only); must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `IReq_i`  in  1  fetch request; held high with `IAddr_i` stable until `IDone_o`.
- `IAddr_i`  in  ADDR_W  fetch address.
- `IRdata_o`  out  DATA_W  fetched word; valid while `IDone_o`=1, held afterwards.
- `IDone_o`  out  1  one-cycle fetch-complete pulse.
- `DReq_i`  in  1  data request; held high with attributes stable until `DDone_o`.
- `DWe_i`  in  1  1 = store, 0 = load.
- `DAddr_i`  in  ADDR_W  data address.
- `DWdata_i`  in  DATA_W  store data.
- `DRdata_o`  out  DATA_W  load data; valid while `DDone_o`=1, held afterwards.
- `DDone_o`  out  1  one-cycle data-complete pulse (loads and stores).
- `MemEn_o`  out  1  memory issue strobe, exactly one cycle per transaction.
- `MemWe_o`  out  1  write enable, qualified by `MemEn_o`.
- `MemAddr_o`  out  ADDR_W  latched transaction address.
- `MemWdata_o`  out  DATA_W  latched store data.
- `MemRdata_i`  in  DATA_W  read data, valid with `MemReady_i`.
- `MemReady_i`  in  1  one-cycle completion from memory (reads and writes).
- `Busy_o`  out  1  1 whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if `DReq_i` or `IReq_i` is high, pick the winner; latch grant, address, we, and wdata into internal registers; go to ISSUE. Otherwise stay.
- Priority: data wins when both requests are high. Fetch wins only if `DReq_i`=0, or if the starvation guard fires.
- ISSUE: `MemEn_o`=1 with the latched `MemWe_o`/`MemAddr_o`/`MemWdata_o`. Go to WAIT unconditionally.
- WAIT: hold the latched attributes with `MemEn_o`=0. On `MemReady_i`, capture `MemRdata_i` into the granted requester's read register; loads and fetches only, stores leave `DRdata_o` unchanged. Go to RESP.
- RESP: pulse `IDone_o` or `DDone_o` for the granted requester, then go to IDLE. The requester samples Done and deasserts or changes its request at this edge.
- `MemReady_i` outside WAIT is ignored.
- Requester inputs are sampled only in IDLE. Changes made mid-transaction do not affect the transaction in flight.
- Reset values: state IDLE. All of `MemEn_o`, `MemWe_o`, `IDone_o`, `DDone_o`, `Busy_o` are 0. `MemAddr_o`, `MemWdata_o`, `IRdata_o`, `DRdata_o` are 0. Starvation counter is 0.
- Reset mid-transaction aborts the transaction: no Done pulse is issued, and any later `MemReady_i` is ignored. Requesters must re-present after reset.

## Timing
- Request seen in IDLE at cycle t. `MemEn_o` is high at t+1. The earliest `MemReady_i` is at t+2. Done is at (ready cycle + 1).
- The minimum transaction is 4 cycles, IDLE through RESP. Back-to-back grants start at earliest the cycle after RESP.
- All outputs are registered or decoded directly from state; there are no combinational input-to-output paths.
- There is no timeout: WAIT persists until `MemReady_i` arrives.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A counter increments on each data grant made while `IReq_i`=1.
  - The counter clears on any fetch grant, and in IDLE when `IReq_i`=0.
  - When the counter equals `STARVE_MAX` and `IReq_i`=1, the next grant goes to fetch even if `DReq_i`=1.
  - The counter saturates at `STARVE_MAX`.
- Undefined: strict data priority, and the counter logic is absent.

## Structure
- Shared package `ucsbece154b_mem_pkg` holds:
  - state encodings (`MA_IDLE`, `MA_ISSUE`, `MA_WAIT`, `MA_RESP`, 2 bits);
  - grant encodings (`GNT_I`, `GNT_D`).
- Sub-module `ucsbece154b_arb_pick` is combinational. It takes both requests plus the starvation-fire flag and returns the grant.

## Test plan
- Fetch only: `IReq_i`=1, `IAddr_i`=0x100, memory returns 0xDEADBEEF two cycles after `MemEn_o`. Expect `MemEn_o` at t+1, `MemWe_o`=0, `IDone_o` at t+4, `IRdata_o`=0xDEADBEEF.
- Simultaneous: `IReq_i` and `DReq_i` both high, data load at 0x200 returns 0x1234. Expect data served first with `DDone_o` and `DRdata_o`=0x1234, then fetch issued in the following IDLE.
- Store: `DWe_i`=1, `DAddr_i`=0x40, `DWdata_i`=0xA5A5A5A5. Expect `MemWe_o`=1 with those values for exactly one cycle, `DDone_o` after ready, and `DRdata_o` unchanged.
- Starvation (macro on, `STARVE_MAX`=2): `DReq_i` is held continuously with new accesses and `IReq_i`=1. Expect the grant sequence D, D, I, D, D, I. With the macro off, expect fetch never granted.
- Reset in WAIT: assert `reset` for one cycle, then pulse `MemReady_i`. Expect no Done pulse, `Busy_o`=0, all outputs at their reset values.
- Long latency: `MemReady_i` arrives 20 cycles after issue. Expect `Busy_o` held, `MemEn_o` low throughout WAIT, and a single Done pulse.
